prefix_adder_bist: RTL and testbench
====================================

Name: prefix_adder_bist

Overview:
- Built-in self-test engine for the 16-bit parallel-prefix adder/subtractor.
- Generates operand vectors and drives the adder's a, b and cin inputs from registers.
- Captures the adder's sum output S, checks it against a golden model, and compacts S into a signature.
- Sits beside the adder at its input and output boundary; lets the adder be checked in silicon and in regression without a testbench.

Parameters:
- N_VEC, 256: number of LFSR vectors per run; must be ≥1.
- DUT_LAT, 0: register stages inside the adder path (0 = combinational adder).
- SEED_A, 16'hACE1: LFSR A seed.
- SEED_B, 16'h1D0F: LFSR B seed.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- abort  in  1  terminate a run; returns to IDLE
- op_a  out  16  registered operand a to the adder
- op_b  out  16  registered operand b to the adder
- op_cin  out  1  registered cin (0 = add, 1 = subtract a-b)
- dut_s  in  16  adder sum output S
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- pass  out  1  valid while done; 1 when err_cnt==0
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF
- fail_exp  out  16  expected sum of the first mismatch
- fail_s  out  16  observed sum of the first mismatch
- fail_idx  out  16  vector index of the first mismatch
- signature  out  16  MISR of all captured dut_s values

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0.
  - LFSR A/B load SEED_A/SEED_B; a zero seed is replaced with 16'h0001.
  - MISR clears to 0.
- Golden model:
  - cin=0: exp = (a + b) mod 2^16.
  - cin=1: exp = (a - b) mod 2^16.
  - exp is computed in 17-bit arithmetic and truncated; no overflow flag is produced.
- LFSRs:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Both LFSRs advance once per launched vector.
  - op_cin = lfsrA[0] ^ lfsrB[15].
- MISR:
  - Same polynomial; on each compare, next = shift(sig) ^ dut_s.
- State machine:
  - IDLE:
    - On start: clear err_cnt, fail_* and MISR; reload LFSRs from seeds; launch vector 0 on that edge; go to RUN.
  - RUN:
    - Launch one vector per cycle: op_* update on the clock edge.
    - After vector N_VEC-1 is launched, go to DRAIN.
  - DRAIN:
    - Hold op_* at the last vector.
    - Stay until every launched vector has been compared, then go to DONE.
  - DONE:
    - done=1; pass, err_cnt, fail_* and signature are held stable.
    - start re-runs exactly as from IDLE, so the run is repeatable.
- Compare pipeline:
  - The expected value and the vector index travel through a DUT_LAT+1 deep shift register.
  - The vector launched at edge k is compared against dut_s at edge k+DUT_LAT+1.
  - busy is high for exactly N_VEC+DUT_LAT+1 cycles; done rises on the following cycle.
- Mismatch:
  - err_cnt increments, saturating.
  - fail_exp, fail_s and fail_idx are written only on the first mismatch of a run.
- start while busy: ignored.
- abort:
  - Takes effect at any state.
  - Goes to IDLE; done=0, busy=0.
  - Results stay frozen at their current values; pass reads 0 in IDLE.
  - abort has priority over start in the same cycle.
- Reset mid-run: immediate return to the reset state; no partial results are retained.

Optional Feature:
- Macro BIST_CORNER_VEC_EN.
- When defined, 8 fixed corner vectors are launched before the LFSR vectors. Format is (a, b, cin):
  1. (0000,0000,0)
  2. (FFFF,0001,0)
  3. (FFFF,FFFF,0)
  4. (55AA,AA55,0)
  5. (0000,0001,1)
  6. (8000,0001,1)
  7. (FFFF,FFFF,1)
  8. (0069,0069,1)
- With the macro, busy lasts N_VEC+8+DUT_LAT+1 cycles and fail_idx counts the corner vectors first.
- The LFSRs do not advance during the corner vectors.
- Without the macro, only LFSR vectors are run and no corner-vector logic is present.

Test Plan:
- Reset, connect the real adder, N_VEC=256, start pulse → busy for 257 cycles, then done=1, pass=1, err_cnt=0, signature equal to the bench model of the MISR.
- Model adder with S bit 7 stuck at 0 → pass=0, err_cnt equal to the count of vectors whose exp[7]=1; fail_idx is the first such index; fail_s = fail_exp & 16'hFF7F.
- BIST_CORNER_VEC_EN defined, golden DUT:
  - vector 1 (FFFF+0001, cin=0) → exp 0000;
  - vector 5 (8000-0001) → exp 7FFF;
  - run → pass=1, busy for N_VEC+9 cycles.
- DUT_LAT=2 with a 2-stage registered adder model → pass=1; busy for N_VEC+3 cycles; a model set to DUT_LAT=1 fails.
- Assert abort 10 cycles into the run, and also drive start on that same cycle → IDLE, busy=0, done=0; a following start completes normally with pass=1.
- Drop rst_n asynchronously mid-RUN (between edges) → all outputs 0 immediately; a second start with the same seeds produces the same signature as the first run.

Source files
------------

// File: rtl/prefix_adder_bist.sv
// BIST engine for the 16-bit prefix adder/subtractor: LFSR operand generation, golden compare, MISR.
// Optional macro BIST_CORNER_VEC_EN prepends 8 fixed corner vectors ahead of the LFSR vectors.
module prefix_adder_bist #(
    parameter int unsigned N_VEC   = 256,
    parameter int unsigned DUT_LAT = 0,
    parameter logic [15:0] SEED_A  = 16'hACE1,
    parameter logic [15:0] SEED_B  = 16'h1D0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_cin,
    input  logic [15:0] dut_s,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] fail_exp,
    output logic [15:0] fail_s,
    output logic [15:0] fail_idx,
    output logic [15:0] signature
);

`ifdef BIST_CORNER_VEC_EN
    localparam int unsigned N_CORNER = 8;
`else
    localparam int unsigned N_CORNER = 0;
`endif
    localparam int unsigned N_TOTAL    = N_VEC + N_CORNER;
    localparam logic [15:0] SEED_A_EFF = (SEED_A == '0) ? 16'h0001 : SEED_A;
    localparam logic [15:0] SEED_B_EFF = (SEED_B == '0) ? 16'h0001 : SEED_B;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

`ifdef BIST_CORNER_VEC_EN
    function automatic logic [32:0] corner_vec(input logic [2:0] i);
        case (i)
            3'd0:    return {16'h0000, 16'h0000, 1'b0};
            3'd1:    return {16'hFFFF, 16'h0001, 1'b0};
            3'd2:    return {16'hFFFF, 16'hFFFF, 1'b0};
            3'd3:    return {16'h55AA, 16'hAA55, 1'b0};
            3'd4:    return {16'h0000, 16'h0001, 1'b1};
            3'd5:    return {16'h8000, 16'h0001, 1'b1};
            3'd6:    return {16'hFFFF, 16'hFFFF, 1'b1};
            default: return {16'h0069, 16'h0069, 1'b1};
        endcase
    endfunction
`endif

    logic [1:0]  state;
    logic [15:0] lfsr_a, lfsr_b;
    logic [31:0] launch_cnt;
    logic [DUT_LAT:0] pv;
    logic [15:0] exp_pipe [0:DUT_LAT];
    logic [15:0] idx_pipe [0:DUT_LAT];

    logic        starting, launching, mism;
    logic [15:0] src_a, src_b, va, vb, nxt_a, nxt_b, exp_v;
    logic        vc, adv;
    logic [31:0] src_cnt;
    logic [16:0] sum17;

    assign starting  = start && !abort && (state == IDLE || state == DONE);
    assign launching = starting || (state == RUN);
    assign mism      = pv[DUT_LAT] && (dut_s != exp_pipe[DUT_LAT]);

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0);

    // A start edge launches vector 0 straight from the seeds, so the LFSR registers are bypassed then.
    always_comb begin
        src_a   = starting ? SEED_A_EFF : lfsr_a;
        src_b   = starting ? SEED_B_EFF : lfsr_b;
        src_cnt = starting ? '0 : launch_cnt;
        va      = src_a;
        vb      = src_b;
        vc      = src_a[0] ^ src_b[15];
        adv     = 1'b1;
`ifdef BIST_CORNER_VEC_EN
        if (src_cnt < N_CORNER) begin
            {va, vb, vc} = corner_vec(src_cnt[2:0]);
            adv          = 1'b0;
        end
`endif
        nxt_a = adv ? lfsr_step(src_a) : src_a;
        nxt_b = adv ? lfsr_step(src_b) : src_b;
        sum17 = vc ? ({1'b0, va} - {1'b0, vb}) : ({1'b0, va} + {1'b0, vb});
        exp_v = sum17[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr_a     <= SEED_A_EFF;
            lfsr_b     <= SEED_B_EFF;
            launch_cnt <= '0;
            pv         <= '0;
            for (int unsigned i = 0; i <= DUT_LAT; i++) begin
                exp_pipe[i] <= '0;
                idx_pipe[i] <= '0;
            end
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            err_cnt    <= '0;
            fail_exp   <= '0;
            fail_s     <= '0;
            fail_idx   <= '0;
            signature  <= '0;
        end else if (abort) begin
            state <= IDLE;
            pv    <= '0;
        end else begin
            for (int unsigned i = DUT_LAT; i > 0; i--) begin
                pv[i]       <= pv[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
            pv[0]       <= launching;
            exp_pipe[0] <= exp_v;
            idx_pipe[0] <= src_cnt[15:0];

            if (launching) begin
                op_a       <= va;
                op_b       <= vb;
                op_cin     <= vc;
                lfsr_a     <= nxt_a;
                lfsr_b     <= nxt_b;
                launch_cnt <= src_cnt + 32'd1;
            end

            if (starting) begin
                err_cnt   <= '0;
                fail_exp  <= '0;
                fail_s    <= '0;
                fail_idx  <= '0;
                signature <= '0;
                state     <= (N_TOTAL == 1) ? DRAIN : RUN;
            end else begin
                if (pv[DUT_LAT])
                    signature <= lfsr_step(signature) ^ dut_s;
                if (mism) begin
                    if (err_cnt == '0) begin
                        fail_exp <= exp_pipe[DUT_LAT];
                        fail_s   <= dut_s;
                        fail_idx <= idx_pipe[DUT_LAT];
                    end
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + 16'd1;
                end
                case (state)
                    RUN:     if (launch_cnt == N_TOTAL - 1) state <= DRAIN;
                    DRAIN:   if (pv == '0) state <= DONE;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prefix_adder_bist.sv
// Bench for prefix_adder_bist: a combinational and a 2-stage adder model, each beside its own BIST instance.
module tb_prefix_adder_bist;

    localparam int unsigned NV = 256;
`ifdef BIST_CORNER_VEC_EN
    localparam int unsigned NC = 8;
`else
    localparam int unsigned NC = 0;
`endif
    localparam int unsigned TOTAL = NV + NC;

    logic clk = 1'b0;
    logic rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] op_a0, op_b0, s0, err0, fexp0, fs0, fidx0, sig0, sum0;
    logic        op_cin0, busy0, done0, pass0;
    logic [15:0] op_a2, op_b2, s2, err2, fexp2, fs2, fidx2, sig2, r1, r2;
    logic        op_cin2, busy2, done2, pass2;

    logic [15:0] fmask = '0, fval = '0;
    logic        lat1 = 1'b0;

    assign sum0 = op_cin0 ? op_a0 - op_b0 : op_a0 + op_b0;
    assign s0   = (sum0 & ~fmask) | (fval & fmask);
    always @(posedge clk) begin
        r1 <= op_cin2 ? op_a2 - op_b2 : op_a2 + op_b2;
        r2 <= r1;
    end
    assign s2 = lat1 ? r1 : r2;

    prefix_adder_bist #(.N_VEC(NV), .DUT_LAT(0), .SEED_A(16'hACE1), .SEED_B(16'h1D0F)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a0), .op_b(op_b0), .op_cin(op_cin0), .dut_s(s0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_exp(fexp0), .fail_s(fs0), .fail_idx(fidx0), .signature(sig0));

    prefix_adder_bist #(.N_VEC(NV), .DUT_LAT(2), .SEED_A(16'hACE1), .SEED_B(16'h1D0F)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a2), .op_b(op_b2), .op_cin(op_cin2), .dut_s(s2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_exp(fexp2), .fail_s(fs2), .fail_idx(fidx2), .signature(sig2));

    int n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: vector list from the polynomial rules, expected sums by plain arithmetic.
    logic [15:0] va[$], vb[$];
    logic        vc[$];
    logic [15:0] m_err, m_fidx, m_fexp, m_fs, m_sig;

    function automatic logic [15:0] poly_shift(input logic [15:0] x);
        return {^(x & 16'h002D), x[15:1]};
    endfunction

    task automatic build_vectors();
        logic [15:0] a, b;
`ifdef BIST_CORNER_VEC_EN
        logic [15:0] ca[8] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h55AA, 16'h0000, 16'h8000, 16'hFFFF, 16'h0069};
        logic [15:0] cb[8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hAA55, 16'h0001, 16'h0001, 16'hFFFF, 16'h0069};
        for (int i = 0; i < 8; i++) begin
            va.push_back(ca[i]); vb.push_back(cb[i]); vc.push_back(i >= 4);
        end
`endif
        a = 16'hACE1;
        b = 16'h1D0F;
        for (int i = 0; i < int'(NV); i++) begin
            va.push_back(a); vb.push_back(b); vc.push_back(a[0] ^ b[15]);
            a = poly_shift(a);
            b = poly_shift(b);
        end
    endtask

    task automatic predict(input logic [15:0] mask, input logic [15:0] val);
        logic [15:0] e, s;
        m_err = 0; m_fidx = 0; m_fexp = 0; m_fs = 0; m_sig = 0;
        for (int i = 0; i < int'(TOTAL); i++) begin
            e = vc[i] ? va[i] - vb[i] : va[i] + vb[i];
            s = (e & ~mask) | (val & mask);
            m_sig = poly_shift(m_sig) ^ s;
            if (s != e) begin
                if (m_err == 0) begin
                    m_fidx = 16'(i); m_fexp = e; m_fs = s;
                end
                if (m_err != 16'hFFFF) m_err++;
            end
        end
    endtask

    task automatic do_run(input bit check_ops, output int b0, output int b2);
        b0 = 0;
        b2 = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (check_ops && cyc < int'(TOTAL))
                check_eq("launch_vec", {op_a0, op_b0, op_cin0}, {va[cyc], vb[cyc], vc[cyc]});
            if (busy0) b0++;
            if (busy2) b2++;
            if (done0 && done2) break;
            @(negedge clk);
        end
        check_eq("run_timeout", {done0, done2}, 2'b11);
    endtask

    int b0, b2;
    logic [15:0] gold_sig;

    initial begin
        build_vectors();
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {op_a0, op_b0, op_cin0, busy0, done0, pass0},
                 {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        check_eq("rst_results", {err0, fexp0, fs0, fidx0}, 64'h0);
        check_eq("rst_sig", sig0, 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // golden run on both instances
        predict(16'h0, 16'h0);
        gold_sig = m_sig;
        do_run(1'b1, b0, b2);
        check_eq("busy_len_lat0", b0, TOTAL + 1);
        check_eq("busy_len_lat2", b2, TOTAL + 3);
        check_eq("gold_pass0", {pass0, err0}, {1'b1, 16'h0});
        check_eq("gold_sig0", sig0, gold_sig);
        check_eq("gold_pass2", {pass2, err2}, {1'b1, 16'h0});
        check_eq("gold_sig2", sig2, gold_sig);

        // S[7] stuck-at-0, and wrong latency on the 2-stage model; rerun from DONE
        fmask = 16'h0080; fval = 16'h0; lat1 = 1'b1;
        predict(fmask, fval);
        do_run(1'b0, b0, b2);
        check_eq("sa0_pass", pass0, 1'b0);
        check_eq("sa0_err", err0, m_err);
        check_eq("sa0_fidx", fidx0, m_fidx);
        check_eq("sa0_fexp", fexp0, m_fexp);
        check_eq("sa0_fs", fs0, fexp0 & 16'hFF7F);
        check_eq("sa0_sig", sig0, m_sig);
        check_eq("lat1_pass", pass2, 1'b0);

        // random stuck-at faults
        for (int k = 0; k < 3; k++) begin
            fmask = 16'h1 << $urandom_range(0, 15);
            fval  = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0;
            lat1  = 1'b0;
            predict(fmask, fval);
            do_run(1'b0, b0, b2);
            check_eq("rnd_err", err0, m_err);
            check_eq("rnd_first", {fidx0, fexp0, fs0}, {m_fidx, m_fexp, m_fs});
            check_eq("rnd_sig", sig0, m_sig);
            check_eq("rnd_pass", pass0, m_err == 0);
        end

        // abort plus start on the same cycle, ten cycles in
        fmask = '0; fval = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk) abort = 1'b0; start = 1'b0;
        check_eq("abort_state", {busy0, done0, pass0, busy2, done2, pass2}, 6'b0);
        @(negedge clk);
        check_eq("abort_stays_idle", {busy0, done0}, 2'b00);
        do_run(1'b1, b0, b2);
        check_eq("post_abort_pass", {pass0, pass2}, 2'b11);
        check_eq("post_abort_sig", sig0, gold_sig);

        // asynchronous reset between edges of a faulty run
        fmask = 16'h0001; fval = 16'hFFFF;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_ops", {op_a0, op_b0, op_cin0, busy0, done0}, 35'h0);
        check_eq("async_rst_res", {err0, fidx0, sig0, fexp0}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        fmask = '0; fval = '0;
        do_run(1'b0, b0, b2);
        check_eq("rerun_sig", sig0, gold_sig);
        check_eq("rerun_pass", {pass0, pass2}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
